router_dest_reader: RTL and testbench

ROUTER_DEST_READER -- requirements
Module: router_dest_reader

---
 rtl/router_dest_reader_if.sv | 28 ++
 rtl/router_dest_reader.sv | 168 ++++++++++++++++
 tb/tb_router_dest_reader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_dest_reader_if.sv
// Router output-FIFO read side plus downstream byte sink and packet status, bundled for router_dest_reader.
interface router_dest_reader_if;
    logic       vld_out;
    logic [7:0] data_out;
    logic       soft_reset;
    logic       read_enb;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic [5:0] pkt_len;
    logic       addr_err;
    logic       pkt_done;
    logic       parity_err;
    logic       abort;
    logic       busy;

    modport master (
        output vld_out, data_out, soft_reset, byte_ready,
        input  read_enb, byte_out, byte_valid, pkt_len, addr_err,
               pkt_done, parity_err, abort, busy
    );

    modport slave (
        input  vld_out, data_out, soft_reset, byte_ready,
        output read_enb, byte_out, byte_valid, pkt_len, addr_err,
               pkt_done, parity_err, abort, busy
    );
endinterface

// File: rtl/router_dest_reader.sv
// Pulls one packet (header, payload, parity) from a router output FIFO,
// streams the payload through a 2-entry buffer and reports address/parity status.
module router_dest_reader #(
    parameter logic [1:0] ID_ADDR = 2'b00
) (
    input logic               clock,
    input logic               resetn,
    router_dest_reader_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] PAY  = 2'd2;
    localparam logic [1:0] PAR  = 2'd3;

    logic [1:0] state_q, state_d;
    logic       rd_q, rd_d;
    logic [6:0] rd_left_q, rd_left_d;
    logic [5:0] cap_left_q, cap_left_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] obuf_q [2];
    logic [7:0] obuf_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic [5:0] pkt_len_q, pkt_len_d;
    logic       addr_err_q, addr_err_d;
    logic       parity_err_q, parity_err_d;
    logic       pkt_done_q, pkt_done_d;
    logic       abort_q, abort_d;

    logic       flush;
    logic       room;
    logic       rd_issue;
    logic       push;
    logic       pop;

    always_comb begin
        state_d      = state_q;
        rd_left_d    = rd_left_q;
        cap_left_d   = cap_left_q;
        acc_d        = acc_q;
        obuf_d       = obuf_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pkt_len_d    = pkt_len_q;
        addr_err_d   = addr_err_q;
        parity_err_d = parity_err_q;
        pkt_done_d   = 1'b0;
        abort_d      = 1'b0;
        push         = 1'b0;
        rd_issue     = 1'b0;

        flush = bus.soft_reset && (state_q != IDLE);
        pop   = (cnt_q != 2'd0) && bus.byte_ready;
        // Buffered bytes plus the byte still in flight must leave a free slot.
        room  = ({1'b0, cnt_q} + {2'b00, rd_q}) < 3'd2;

        if (bus.vld_out && room && !flush) begin
            case (state_q)
                IDLE:     rd_issue = 1'b1;
                PAY, PAR: rd_issue = (rd_left_q != 7'd0);
                default:  rd_issue = 1'b0;
            endcase
        end
        rd_d = rd_issue;

        case (state_q)
            IDLE: begin
                if (rd_issue) state_d = HDR;
            end
            HDR: begin
                if (rd_q) begin
                    pkt_len_d    = bus.data_out[7:2];
                    addr_err_d   = (bus.data_out[1:0] != ID_ADDR);
                    parity_err_d = 1'b0;
                    acc_d        = bus.data_out;
                    cap_left_d   = bus.data_out[7:2];
                    rd_left_d    = {1'b0, bus.data_out[7:2]} + 7'd1;
                    state_d      = (bus.data_out[7:2] == 6'd0) ? PAR : PAY;
                end
            end
            PAY: begin
                if (rd_issue) rd_left_d = rd_left_q - 7'd1;
                if (rd_q) begin
                    push       = 1'b1;
                    acc_d      = acc_q ^ bus.data_out;
                    cap_left_d = cap_left_q - 6'd1;
                    if (cap_left_q == 6'd1) state_d = PAR;
                end
            end
            default: begin
                if (rd_issue) rd_left_d = rd_left_q - 7'd1;
                if (rd_q) begin
                    pkt_done_d   = 1'b1;
                    parity_err_d = (acc_q != bus.data_out);
                    state_d      = IDLE;
                end
            end
        endcase

        if (push) begin
            obuf_d[wr_ptr_q] = bus.data_out;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

        // A flush discards the whole packet, including any capture landing this cycle.
        if (flush) begin
            state_d      = IDLE;
            rd_d         = 1'b0;
            cnt_d        = 2'd0;
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            pkt_len_d    = pkt_len_q;
            addr_err_d   = addr_err_q;
            parity_err_d = parity_err_q;
            pkt_done_d   = 1'b0;
            abort_d      = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            rd_q         <= 1'b0;
            rd_left_q    <= '0;
            cap_left_q   <= '0;
            acc_q        <= '0;
            obuf_q[0]    <= '0;
            obuf_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            pkt_len_q    <= '0;
            addr_err_q   <= 1'b0;
            parity_err_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            rd_left_q    <= rd_left_d;
            cap_left_q   <= cap_left_d;
            acc_q        <= acc_d;
            obuf_q       <= obuf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            pkt_len_q    <= pkt_len_d;
            addr_err_q   <= addr_err_d;
            parity_err_q <= parity_err_d;
            pkt_done_q   <= pkt_done_d;
            abort_q      <= abort_d;
        end
    end

    // read_enb is combinational, so it is gated to stay low while reset is held.
    assign bus.read_enb   = rd_issue && resetn;
    assign bus.byte_out   = obuf_q[rd_ptr_q];
    assign bus.byte_valid = (cnt_q != 2'd0);
    assign bus.pkt_len    = pkt_len_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.abort      = abort_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_router_dest_reader.sv
// Randomized bench for router_dest_reader: a byte-queue FIFO source and a
// packet-level expectation model (payload order, length, address and parity flags).
module tb_router_dest_reader;
    localparam logic [1:0] ID = 2'b00;

    typedef struct packed {
        logic [5:0] len;
        logic       aerr;
        logic       perr;
    } pkt_t;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    router_dest_reader_if bus ();

    router_dest_reader #(.ID_ADDR(ID)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  src_q[$];
    logic [7:0]  exp_bytes[$];
    pkt_t        exp_pkts[$];
    logic [7:0]  pay_q[$];
    logic [7:0]  pend;
    bit          pend_valid = 0;
    int          rdy_mode = 1;
    bit          sr_drive = 0;
    bit          abort_ok = 0;
    int unsigned n_deliv = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_byte;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] calc_par(input logic [7:0] hdr);
        logic [7:0] a;
        a = hdr;
        foreach (pay_q[i]) a ^= pay_q[i];
        return a;
    endfunction

    // Queues header, pay_q contents and parity; records what the reader should report.
    task automatic add_pkt(input logic [7:0] hdr, input logic [7:0] par);
        pkt_t p;
        src_q.push_back(hdr);
        foreach (pay_q[i]) begin
            src_q.push_back(pay_q[i]);
            exp_bytes.push_back(pay_q[i]);
        end
        src_q.push_back(par);
        p.len  = hdr[7:2];
        p.aerr = (hdr[1:0] != ID);
        p.perr = (par != calc_par(hdr));
        exp_pkts.push_back(p);
    endtask

    task automatic cycle();
        pkt_t e;
        @(negedge clock);
        if (pend_valid) begin
            bus.data_out = pend;
            pend_valid   = 0;
        end else begin
            bus.data_out = 8'($urandom);
        end
        bus.vld_out    = (src_q.size() != 0);
        bus.byte_ready = (rdy_mode == 1) ? 1'b1 :
                         (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
        bus.soft_reset = sr_drive;
        #1;
        if (prev_stall) begin
            chk("hold_valid", bus.byte_valid, 1);
            chk("hold_byte", bus.byte_out, prev_byte);
        end
        prev_stall = bus.byte_valid && !bus.byte_ready && !sr_drive;
        prev_byte  = bus.byte_out;
        if (bus.read_enb) begin
            chk("rd_vld", bus.vld_out, 1);
            if (src_q.size() != 0) begin
                pend       = src_q.pop_front();
                pend_valid = 1;
            end
        end
        if (bus.byte_valid && bus.byte_ready && !sr_drive) begin
            if (exp_bytes.size() != 0) chk("byte", bus.byte_out, exp_bytes.pop_front());
            else                       chk("byte_extra", bus.byte_valid, 0);
            n_deliv++;
        end
        if (bus.pkt_done) begin
            if (exp_pkts.size() != 0) begin
                e = exp_pkts.pop_front();
                chk("pkt_len", bus.pkt_len, e.len);
                chk("addr_err", bus.addr_err, e.aerr);
                chk("parity_err", bus.parity_err, e.perr);
            end else begin
                chk("pkt_done_extra", bus.pkt_done, 0);
            end
        end
        if (bus.abort && !abort_ok) chk("abort_spur", bus.abort, 0);
    endtask

    task automatic drain(input string tag, input int unsigned max);
        int unsigned n = 0;
        while ((src_q.size() != 0 || pend_valid || exp_bytes.size() != 0 ||
                exp_pkts.size() != 0) && n < max) begin
            cycle();
            n++;
        end
        chk({"drain_", tag}, src_q.size() + exp_bytes.size() + exp_pkts.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_read_enb"}, bus.read_enb, 0);
        chk({tag, "_byte_valid"}, bus.byte_valid, 0);
        chk({tag, "_byte_out"}, bus.byte_out, 0);
        chk({tag, "_pkt_len"}, bus.pkt_len, 0);
        chk({tag, "_pkt_done"}, bus.pkt_done, 0);
        chk({tag, "_abort"}, bus.abort, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_addr_err"}, bus.addr_err, 0);
        chk({tag, "_parity_err"}, bus.parity_err, 0);
    endtask

    task automatic clear_model();
        src_q.delete();
        exp_bytes.delete();
        exp_pkts.delete();
        pend_valid = 0;
        prev_stall = 0;
    endtask

    task automatic rand_payload(input int unsigned len);
        pay_q.delete();
        for (int unsigned i = 0; i < len; i++) pay_q.push_back(8'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned len;
        int unsigned npk;
        logic [1:0]  addr;
        logic [7:0]  hdr;
        logic [7:0]  par;

        resetn         = 1'b0;
        bus.vld_out    = 1'b1;
        bus.data_out   = 8'hA5;
        bus.soft_reset = 1'b0;
        bus.byte_ready = 1'b1;
        #12;
        check_zero("reset");
        @(negedge clock);
        bus.vld_out = 1'b0;
        resetn      = 1'b1;

        // Nominal packet, correct parity
        rdy_mode = 1;
        pay_q = '{8'h11, 8'h22, 8'h33};
        add_pkt(8'h0C, 8'h0C);
        drain("t30", 100);
        chk("t30_perr", bus.parity_err, 0);

        // Same packet, bad parity; flag must persist while idle
        add_pkt(8'h0C, 8'hFF);
        drain("t31", 100);
        repeat (3) cycle();
        chk("t31_perr_hold", bus.parity_err, 1);

        // Zero-length packet with a foreign address
        pay_q.delete();
        add_pkt(8'h01, 8'h01);
        drain("t32", 100);
        chk("t32_aerr", bus.addr_err, 1);

        // Sink stalled: only two payload bytes may be fetched
        rdy_mode = 0;
        rand_payload(5);
        add_pkt(8'h14, calc_par(8'h14));
        repeat (20) cycle();
        chk("t33_src_left", src_q.size(), 4);
        chk("t33_valid", bus.byte_valid, 1);
        rdy_mode = 1;
        drain("t33", 100);

        // Soft reset after two delivered bytes
        rand_payload(5);
        add_pkt(8'h14, calc_par(8'h14));
        n_deliv = 0;
        for (int i = 0; i < 60 && n_deliv < 2; i++) cycle();
        chk("t34_reach", n_deliv, 2);
        rdy_mode = 0;
        sr_drive = 1;
        abort_ok = 1;
        cycle();
        chk("t34_sr_vld", bus.vld_out, 1);
        chk("t34_sr_rd", bus.read_enb, 0);
        sr_drive = 0;
        clear_model();
        cycle();
        chk("t34_abort", bus.abort, 1);
        chk("t34_valid", bus.byte_valid, 0);
        chk("t34_busy", bus.busy, 0);
        cycle();
        chk("t34_abort_pulse", bus.abort, 0);
        abort_ok = 0;
        repeat (3) cycle();
        rdy_mode = 2;
        pay_q = '{8'h11, 8'h22, 8'h33};
        add_pkt(8'h0C, 8'h0C);
        drain("t34_next", 200);

        // Random back-to-back packets with a randomly stalling sink
        for (int unsigned it = 0; it < 25; it++) begin
            rdy_mode = 2;
            npk = $urandom_range(1, 3);
            for (int unsigned k = 0; k < npk; k++) begin
                len  = $urandom_range(0, 6);
                addr = ($urandom_range(0, 1) != 0) ? ID : 2'($urandom_range(0, 3));
                hdr  = {6'(len), addr};
                rand_payload(len);
                par = calc_par(hdr);
                if ($urandom_range(0, 3) == 0) par ^= (8'h01 << $urandom_range(0, 7));
                add_pkt(hdr, par);
            end
            drain("rand", 600);
        end

        // Asynchronous reset mid-payload
        rdy_mode = 1;
        rand_payload(5);
        add_pkt(8'h17, calc_par(8'h17));
        n_deliv = 0;
        for (int i = 0; i < 60 && n_deliv < 1; i++) cycle();
        chk("t35_reach", n_deliv, 1);
        chk("t35_busy_pre", bus.busy, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_zero("t35");
        repeat (2) @(posedge clock);
        clear_model();
        @(negedge clock);
        bus.vld_out = 1'b0;
        resetn      = 1'b1;
        pay_q = '{8'h11, 8'h22, 8'h33};
        add_pkt(8'h0C, 8'h0C);
        drain("t35_next", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
